mips_multicycle_ctrl: RTL and testbench
=======================================

Name: mips_multicycle_ctrl

Overview:
Main control FSM for the multi-cycle MIPS datapath. It sequences the shared ALU, register file, sign-extend unit and unified instruction/data memory across fetch, decode, execute, memory and writeback steps. It also handles the memory ready handshake and a wait-timeout watchdog. It sits beside the ALU decoder, which consumes aluop.

Parameters:
WAIT_LIMIT, 16, max cycles spent waiting on memready in any memory state before timeout (1..255)
CNT_W, 8, width of wait counter; must hold WAIT_LIMIT

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
op  in  6  opcode field instr[31:26] from instruction register
zero  in  1  ALU zero flag
memready  in  1  memory access complete this cycle
pcen  out  1  PC load enable (pcwrite OR (branch AND zero))
memwrite  out  1  memory write strobe
irwrite  out  1  instruction register load
regwrite  out  1  register file write
alusrca  out  1  0=PC, 1=register A
alusrcb  out  2  00=B, 01=const 4, 10=sign-extended imm, 11=sign-extended imm<<2
iord  out  1  0=PC address, 1=ALUOut address
memtoreg  out  1  writeback source 0=ALUOut, 1=data register
regdst  out  1  0=rt, 1=rd
pcsrc  out  2  00=ALU result, 01=ALUOut, 10=jump target
aluop  out  2  00=add, 01=sub, 10=funct-decoded
illegal_op  out  1  one-cycle pulse on unsupported opcode
mem_timeout  out  1  one-cycle pulse on memready watchdog expiry
state_o  out  4  current state encoding, debug

Behaviour:
- State register and wait counter update on rising clk. Reset low forces state=FETCH and counter=0 immediately.
- While reset is low, every write enable (pcen, memwrite, irwrite, regwrite) and both pulse outputs are 0. Muxes take FETCH values. state_o=0.
- Encoding: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11. Codes 12-15 go to FETCH next cycle with all enables 0.
- Outputs are Moore-decoded from state. The exceptions are memready-qualified enables and pulses. Unlisted outputs are 0.
- FETCH: iord=0, alusrcb=01, aluop=00, pcsrc=00. irwrite=pcen=memready. Stay until memready=1, then DECODE.
- DECODE: alusrcb=11, aluop=00 (branch target precompute).
  - op 100011/101011 -> MEMADR
  - 000000 -> EXEC
  - 000100 -> BRANCH
  - 001000 -> ADDIEX
  - 000010 -> JUMP
  - other -> FETCH with illegal_op=1 for this cycle
- MEMADR: alusrca=1, alusrcb=10, aluop=00. lw -> MEMRD, sw -> MEMWR.
- MEMRD: iord=1. Stay until memready, then MEMWB.
- MEMWB: regdst=0, memtoreg=1, regwrite=1 -> FETCH.
- MEMWR: iord=1, memwrite=1 held until memready, then FETCH.
- EXEC: alusrca=1, alusrcb=00, aluop=10 -> ALUWB.
- ALUWB: regdst=1, memtoreg=0, regwrite=1 -> FETCH.
- BRANCH: alusrca=1, alusrcb=00, aluop=01, pcsrc=01, branch=1. pcen=zero -> FETCH.
- ADDIEX: alusrca=1, alusrcb=10, aluop=00 -> ADDIWB.
- ADDIWB: regdst=0, memtoreg=0, regwrite=1 -> FETCH.
- JUMP: pcsrc=10, pcen=1 -> FETCH.
- Wait counter:
  - Cleared on every state change.
  - Increments each cycle in FETCH/MEMRD/MEMWR while memready=0.
  - When the counter reaches WAIT_LIMIT-1 with memready still 0: mem_timeout pulses one cycle, state goes to FETCH, and no enables assert that cycle.
  - memready=1 on the same cycle as the limit wins: normal transition, no timeout.
- op is sampled only in DECODE and MEMADR. Changes elsewhere have no effect.
- Reset asserted mid-instruction abandons it. No partial writes occur after reset falls.

Test Plan:
- Reset low mid-EXEC, then release, memready=1 -> state_o=0 during reset with all enables 0. After release: FETCH, irwrite=pcen=1, then DECODE.
- lw (op=100011), memready=1 always -> state_o 0,1,2,3,4,0. alusrcb=10 in MEMADR. regwrite=memtoreg=1 only in MEMWB. 5 cycles total.
- beq (op=000100) run twice, zero=1 then zero=0 -> BRANCH with pcsrc=01, aluop=01. pcen=1 first run, pcen=0 second. Both return to FETCH.
- sw with memready held 0 for 3 cycles in MEMWR -> memwrite=1 for 4 cycles, exits to FETCH on the 4th. regwrite never asserts.
- Opcode 111111 in DECODE -> illegal_op=1 for exactly one cycle, next state FETCH, no write enables asserted.
- WAIT_LIMIT=16, memready=0 forever in FETCH -> mem_timeout pulses on cycle 16. irwrite, pcen and state_o stay 0 throughout; counter restarts.

Source files
------------

// File: rtl/mips_multicycle_ctrl_if.sv
// Control bundle between the multi-cycle MIPS main controller and its datapath.
// The controller drives the datapath strobes and mux selects. The datapath returns the opcode, zero flag and memory ready.
interface mips_multicycle_ctrl_if;
    logic [5:0] op;
    logic       zero;
    logic       memready;

    logic       pcen;
    logic       memwrite;
    logic       irwrite;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic       iord;
    logic       memtoreg;
    logic       regdst;
    logic [1:0] pcsrc;
    logic [1:0] aluop;
    logic       illegal_op;
    logic       mem_timeout;
    logic [3:0] state_o;

    modport master (
        input  op, zero, memready,
        output pcen, memwrite, irwrite, regwrite, alusrca, alusrcb, iord,
               memtoreg, regdst, pcsrc, aluop, illegal_op, mem_timeout, state_o
    );

    modport slave (
        output op, zero, memready,
        input  pcen, memwrite, irwrite, regwrite, alusrca, alusrcb, iord,
               memtoreg, regdst, pcsrc, aluop, illegal_op, mem_timeout, state_o
    );
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// Main sequencing FSM for the multi-cycle MIPS datapath.
// It includes a memready wait watchdog that abandons a stalled access and returns to FETCH.
module mips_multicycle_ctrl #(
    parameter int WAIT_LIMIT = 16,
    parameter int CNT_W      = 8
) (
    input logic                   clk,
    input logic                   reset,
    mips_multicycle_ctrl_if.master bus
);

    localparam logic [3:0] S_FETCH  = 4'd0;
    localparam logic [3:0] S_DECODE = 4'd1;
    localparam logic [3:0] S_MEMADR = 4'd2;
    localparam logic [3:0] S_MEMRD  = 4'd3;
    localparam logic [3:0] S_MEMWB  = 4'd4;
    localparam logic [3:0] S_MEMWR  = 4'd5;
    localparam logic [3:0] S_EXEC   = 4'd6;
    localparam logic [3:0] S_ALUWB  = 4'd7;
    localparam logic [3:0] S_BRANCH = 4'd8;
    localparam logic [3:0] S_ADDIEX = 4'd9;
    localparam logic [3:0] S_ADDIWB = 4'd10;
    localparam logic [3:0] S_JUMP   = 4'd11;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [CNT_W-1:0] LIMIT_M1 = CNT_W'(WAIT_LIMIT - 1);

    logic [3:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             waiting;
    logic             limit_hit;

    assign waiting   = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
    // A same-cycle memready takes priority over the watchdog expiry.
    assign limit_hit = waiting && !bus.memready && (cnt_q == LIMIT_M1);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_FETCH:  if (bus.memready) state_d = S_DECODE;
            S_DECODE: begin
                unique case (bus.op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXEC;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JUMP;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                if (bus.op == OP_LW)      state_d = S_MEMRD;
                else if (bus.op == OP_SW) state_d = S_MEMWR;
                else                      state_d = S_FETCH;
            end
            S_MEMRD:  if (bus.memready) state_d = S_MEMWB;
            S_MEMWB:  state_d = S_FETCH;
            S_MEMWR:  if (bus.memready) state_d = S_FETCH;
            S_EXEC:   state_d = S_ALUWB;
            S_ALUWB:  state_d = S_FETCH;
            S_BRANCH: state_d = S_FETCH;
            S_ADDIEX: state_d = S_ADDIWB;
            S_ADDIWB: state_d = S_FETCH;
            S_JUMP:   state_d = S_FETCH;
            default:  state_d = S_FETCH;
        endcase
        if (limit_hit) state_d = S_FETCH;
    end

    // A timeout in FETCH keeps the state unchanged, so it clears the counter explicitly.
    always_comb begin
        cnt_d = cnt_q;
        if ((state_d != state_q) || limit_hit) cnt_d = '0;
        else if (waiting && !bus.memready)     cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_FETCH;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    logic pcwrite_raw, branch_raw, memwrite_raw, irwrite_raw, regwrite_raw, illegal_raw;
    logic en_ok;

    always_comb begin
        pcwrite_raw  = 1'b0;
        branch_raw   = 1'b0;
        memwrite_raw = 1'b0;
        irwrite_raw  = 1'b0;
        regwrite_raw = 1'b0;
        illegal_raw  = 1'b0;
        bus.alusrca  = 1'b0;
        bus.alusrcb  = 2'b00;
        bus.iord     = 1'b0;
        bus.memtoreg = 1'b0;
        bus.regdst   = 1'b0;
        bus.pcsrc    = 2'b00;
        bus.aluop    = 2'b00;
        unique case (state_q)
            S_FETCH: begin
                bus.alusrcb = 2'b01;
                irwrite_raw = bus.memready;
                pcwrite_raw = bus.memready;
            end
            S_DECODE: begin
                bus.alusrcb = 2'b11;
                illegal_raw = !(bus.op inside {OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_J});
            end
            S_MEMADR, S_ADDIEX: begin
                bus.alusrca = 1'b1;
                bus.alusrcb = 2'b10;
            end
            S_MEMRD:  bus.iord = 1'b1;
            S_MEMWB: begin
                bus.memtoreg = 1'b1;
                regwrite_raw = 1'b1;
            end
            S_MEMWR: begin
                bus.iord     = 1'b1;
                memwrite_raw = 1'b1;
            end
            S_EXEC: begin
                bus.alusrca = 1'b1;
                bus.aluop   = 2'b10;
            end
            S_ALUWB: begin
                bus.regdst   = 1'b1;
                regwrite_raw = 1'b1;
            end
            S_BRANCH: begin
                bus.alusrca = 1'b1;
                bus.aluop   = 2'b01;
                bus.pcsrc   = 2'b01;
                branch_raw  = 1'b1;
            end
            S_ADDIWB: regwrite_raw = 1'b1;
            S_JUMP: begin
                bus.pcsrc   = 2'b10;
                pcwrite_raw = 1'b1;
            end
            default: ;
        endcase
    end

    // Strobes are forced low while in reset and on the watchdog expiry cycle.
    assign en_ok           = reset && !limit_hit;
    assign bus.pcen        = en_ok && (pcwrite_raw || (branch_raw && bus.zero));
    assign bus.memwrite    = en_ok && memwrite_raw;
    assign bus.irwrite     = en_ok && irwrite_raw;
    assign bus.regwrite    = en_ok && regwrite_raw;
    assign bus.illegal_op  = reset && illegal_raw;
    assign bus.mem_timeout = reset && limit_hit;
    assign bus.state_o     = state_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Randomized scoreboard bench for mips_multicycle_ctrl.
// The driver walks each instruction through its step list and queues the expected outputs for every cycle. A monitor compares them on the falling edge.
module tb_mips_multicycle_ctrl;

    localparam int WAIT_LIMIT = 16;

    localparam int P_F = 0, P_D = 1, P_MA = 2, P_MR = 3, P_MWB = 4, P_MWR = 5;
    localparam int P_EX = 6, P_AWB = 7, P_BR = 8, P_AIX = 9, P_AIW = 10, P_J = 11;

    typedef struct packed {
        logic [3:0] st;
        logic       pcen, memwrite, irwrite, regwrite, alusrca;
        logic [1:0] alusrcb;
        logic       iord, memtoreg, regdst;
        logic [1:0] pcsrc, aluop;
        logic       illegal, timeout;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    mips_multicycle_ctrl_if ifc();

    mips_multicycle_ctrl #(.WAIT_LIMIT(WAIT_LIMIT), .CNT_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc)
    );

    always #5 clk = ~clk;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_fail = 0;

    function automatic exp_t step_exp(input int ph, input bit mr, input bit z, input bit to);
        exp_t e;
        e = '0;
        e.st = 4'(ph);
        e.timeout = to;
        case (ph)
            P_F:   begin e.alusrcb = 2'b01; e.irwrite = mr && !to; e.pcen = mr && !to; end
            P_D:   e.alusrcb = 2'b11;
            P_MA:  begin e.alusrca = 1'b1; e.alusrcb = 2'b10; end
            P_MR:  e.iord = 1'b1;
            P_MWB: begin e.memtoreg = 1'b1; e.regwrite = 1'b1; end
            P_MWR: begin e.iord = 1'b1; e.memwrite = !to; end
            P_EX:  begin e.alusrca = 1'b1; e.aluop = 2'b10; end
            P_AWB: begin e.regdst = 1'b1; e.regwrite = 1'b1; end
            P_BR:  begin e.alusrca = 1'b1; e.aluop = 2'b01; e.pcsrc = 2'b01; e.pcen = z; end
            P_AIX: begin e.alusrca = 1'b1; e.alusrcb = 2'b10; end
            P_AIW: e.regwrite = 1'b1;
            P_J:   begin e.pcsrc = 2'b10; e.pcen = 1'b1; end
            default: ;
        endcase
        return e;
    endfunction

    function automatic exp_t reset_exp();
        exp_t e;
        e = '0;
        e.alusrcb = 2'b01;
        return e;
    endfunction

    always @(negedge clk) begin
        exp_t e, g;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            g = '{ifc.state_o, ifc.pcen, ifc.memwrite, ifc.irwrite, ifc.regwrite, ifc.alusrca,
                  ifc.alusrcb, ifc.iord, ifc.memtoreg, ifc.regdst, ifc.pcsrc, ifc.aluop,
                  ifc.illegal_op, ifc.mem_timeout};
            n_cmp++;
            if (g !== e) begin
                n_fail++;
                $display("FAIL ctrl_outputs t=%0t step=%0d got=%b required=%b", $time, e.st, g, e);
            end
        end
    end

    // One clock of stimulus: apply inputs, queue what this cycle must show, advance.
    task automatic cyc(input int ph, input bit mr, input bit z, input logic [5:0] opv,
                       input bit ill, input bit to);
        exp_t e;
        ifc.memready = mr;
        ifc.zero     = z;
        ifc.op       = opv;
        e = step_exp(ph, mr, z, to);
        e.illegal = ill;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic reset_cycle();
        ifc.memready = 1'b1;
        ifc.zero     = 1'b1;
        ifc.op       = 6'($urandom);
        sb_q.push_back(reset_exp());
        @(posedge clk);
        #1;
    endtask

    // Memory wait step: 'stall' not-ready cycles, then ready, unless the watchdog fires first.
    task automatic wait_phase(input int ph, input int stall, output bit timed_out);
        int cnt;
        int left;
        bit mr, to;
        cnt = 0;
        left = stall;
        timed_out = 1'b0;
        for (int guard = 0; guard < WAIT_LIMIT + 2; guard++) begin
            mr = (left == 0);
            to = !mr && (cnt == WAIT_LIMIT - 1);
            cyc(ph, mr, 1'($urandom), 6'($urandom), 1'b0, to);
            if (mr) return;
            if (to) begin
                timed_out = 1'b1;
                return;
            end
            cnt++;
            left--;
        end
    endtask

    function automatic bit is_legal(input logic [5:0] o);
        return o inside {6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010};
    endfunction

    task automatic fetch_decode(input logic [5:0] opv, input int fstall);
        bit to;
        int st;
        st = fstall;
        for (int k = 0; k < 8; k++) begin
            wait_phase(P_F, st, to);
            if (!to) break;
            st = 0;
        end
        cyc(P_D, 1'($urandom), 1'($urandom), opv, !is_legal(opv), 1'b0);
    endtask

    task automatic run_instr(input logic [5:0] opv, input int fstall, input int mstall, input bit z);
        bit to;
        fetch_decode(opv, fstall);
        case (opv)
            6'b100011: begin
                cyc(P_MA, 1'($urandom), 1'($urandom), opv, 1'b0, 1'b0);
                wait_phase(P_MR, mstall, to);
                if (!to) cyc(P_MWB, 1'($urandom), 1'($urandom), 6'($urandom), 1'b0, 1'b0);
            end
            6'b101011: begin
                cyc(P_MA, 1'($urandom), 1'($urandom), opv, 1'b0, 1'b0);
                wait_phase(P_MWR, mstall, to);
            end
            6'b000000: begin
                cyc(P_EX,  1'($urandom), 1'($urandom), 6'($urandom), 1'b0, 1'b0);
                cyc(P_AWB, 1'($urandom), 1'($urandom), 6'($urandom), 1'b0, 1'b0);
            end
            6'b000100: cyc(P_BR, 1'($urandom), z, 6'($urandom), 1'b0, 1'b0);
            6'b001000: begin
                cyc(P_AIX, 1'($urandom), 1'($urandom), 6'($urandom), 1'b0, 1'b0);
                cyc(P_AIW, 1'($urandom), 1'($urandom), 6'($urandom), 1'b0, 1'b0);
            end
            6'b000010: cyc(P_J, 1'($urandom), 1'($urandom), 6'($urandom), 1'b0, 1'b0);
            default: ;
        endcase
    endtask

    function automatic int pick_stall();
        int r;
        r = $urandom_range(0, 99);
        if (r < 65) return 0;
        if (r < 93) return $urandom_range(1, 5);
        return $urandom_range(12, 20);
    endfunction

    initial begin
        logic [5:0] ops[6];
        logic [5:0] o;
        ops[0] = 6'b100011; ops[1] = 6'b101011; ops[2] = 6'b000000;
        ops[3] = 6'b000100; ops[4] = 6'b001000; ops[5] = 6'b000010;
        ifc.memready = 1'b1;
        ifc.zero     = 1'b0;
        ifc.op       = 6'd0;

        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) reset_cycle();
        reset = 1'b1;

        // Abandon an R-type in EXEC with reset, then restart cleanly.
        fetch_decode(6'b000000, 0);
        reset = 1'b0;
        for (int i = 0; i < 2; i++) reset_cycle();
        reset = 1'b1;

        run_instr(6'b100011, 0, 0, 1'b0);
        run_instr(6'b000100, 0, 0, 1'b1);
        run_instr(6'b000100, 0, 0, 1'b0);
        run_instr(6'b101011, 0, 3, 1'b0);
        run_instr(6'b111111, 0, 0, 1'b0);
        run_instr(6'b001000, 20, 0, 1'b0);
        run_instr(6'b100011, 0, 15, 1'b0);
        run_instr(6'b101011, 0, 18, 1'b0);
        run_instr(6'b000010, 15, 0, 1'b0);

        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 9) == 0) o = 6'($urandom);
            else o = ops[$urandom_range(0, 5)];
            run_instr(o, pick_stall(), pick_stall(), 1'($urandom));
        end

        @(negedge clk);
        #1;
        if (sb_q.size() != 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL scoreboard_drain left=%0d required=0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
